fft_in_loader: RTL and testbench
================================

FFT_IN_LOADER -- requirements
Module: fft_in_loader

Interface
REQ-001 SHALL have parameter N_FFT, default 4096, meaning samples per frame.
REQ-002 SHALL have parameter LANES, default 4, meaning samples delivered per cycle to the FFT core.
REQ-003 SHALL have parameter DW, default 64, meaning complex sample width (real [63:32], imag [31:0]).
REQ-004 SHALL have port CLK  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port RSTn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port S_VALID  input  1  upstream sample valid.
REQ-007 SHALL have port S_READY  output  1  loader can accept a sample.
REQ-008 SHALL have port S_DATA  input  DW  upstream sample.
REQ-009 SHALL have port START  output  1  one-cycle frame-start pulse to the FFT core.
REQ-010 SHALL have port DONE  input  1  FFT core output-phase indicator.
REQ-011 SHALL have ports D0, D1, D2, D3  output  DW each  four parallel samples to the FFT core.
REQ-012 SHALL have port BUSY  output  1  high whenever the read FSM is not IDLE.

Function
REQ-013 SHALL accept one sample per cycle when S_VALID and S_READY are both high.
REQ-014 SHALL place sample n of a frame (n = 0..N_FFT-1) in word n/4, lane n%4, of the current write bank; lane k drives Dk.
REQ-015 SHALL hold two banks (ping-pong), each N_FFT/LANES = 1024 words of LANES*DW bits, with one full flag per bank.
REQ-016 SHALL set the write bank's full flag and toggle the write bank on acceptance of sample N_FFT-1.
REQ-017 SHALL drive S_READY = not full[wbank], combinationally from registered state only.
REQ-018 SHALL implement read FSM states IDLE, STRT, STRM, WHI, WLO.
REQ-019 IDLE -> STRT when full[rbank]=1.
REQ-020 STRT lasts one cycle; START=1 only in STRT; issues read of word 0.
REQ-021 STRM lasts exactly 1024 cycles; word k SHALL appear on D0..D3 in cycle t+1+k, where t is the STRT cycle.
REQ-022 STRM -> WHI after word 1023; WHI -> WLO when DONE=1; WLO -> IDLE when DONE=0.
REQ-023 On the WLO -> IDLE transition, SHALL clear full[rbank] and toggle rbank.
REQ-024 D0..D3 SHALL be registered and SHALL read 0 in every cycle outside the STRM window.
REQ-025 Write address SHALL wrap 1023 -> 0 at frame end; read address likewise; no saturation.
REQ-026 Both banks full: S_READY=0, upstream stalls with no data loss.
REQ-027 Fill completing in the same cycle as a bank release SHALL update both flags independently; wbank != rbank whenever both are active by construction.
REQ-028 DONE pulses seen outside WHI/WLO SHALL be ignored.

Reset
REQ-029 RSTn low SHALL asynchronously force: FSM=IDLE, wbank=rbank=0, both full flags=0, write/read counters=0, START=0, D0..D3=0, BUSY=0, S_READY=1 after release.
REQ-030 Reset mid-frame SHALL discard all partial and full frames; RAM contents need not be cleared.

Structure
REQ-031 Package fft_pkg SHALL hold N_FFT, LANES, DW, WORDS=N_FFT/LANES, address width clog2(WORDS), and the read-FSM state enum.
REQ-032 SHALL instantiate sub-module fft_bank_ram (WORDS x LANES*DW, one write port, one synchronous read port, 1-cycle latency) twice, once per bank.

Verification
REQ-033 Stream samples 0..4095 with S_DATA=n, S_VALID held high; SHALL see START 1 cycle, then D0..D3 = 4k..4k+3 for k=0..1023 on consecutive cycles, then 0.
REQ-034 Stream 3 frames back-to-back with DONE held low; SHALL see S_READY fall after sample 8191 and stay low until DONE pulses high then low; frame 3 data intact.
REQ-035 Toggle S_VALID randomly (50%) over one frame; D sequence SHALL be identical to REQ-033.
REQ-036 Assert RSTn low at sample 2000 of frame 1, then stream a new frame of n+0x1000; SHALL see no START before the new frame completes, and D0 of word 0 = 0x1000.
REQ-037 Pulse DONE during STRM; FSM SHALL stay in STRM and count all 1024 words.
REQ-038 Fill bank 1 in the same cycle bank 0 is released; SHALL see START for bank 1 exactly 2 cycles later (IDLE, then STRT).

Source files
------------

// File: rtl/fft_in_loader_pkg.sv
// Shared constants and read-FSM state encoding for the FFT input loader.
// Default geometry: 4096-sample frames delivered four samples per cycle.
package fft_pkg;

    localparam int N_FFT = 4096;
    localparam int LANES = 4;
    localparam int DW    = 64;
    localparam int WORDS = N_FFT / LANES;
    localparam int AW    = $clog2(WORDS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STRT = 3'd1,
        ST_STRM = 3'd2,
        ST_WHI  = 3'd3,
        ST_WLO  = 3'd4
    } rd_state_t;

endpackage

// File: rtl/fft_bank_ram.sv
// One ping-pong bank: per-lane write enables, synchronous read (1-cycle latency).
// Contents are never reset.
module fft_bank_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10,
    parameter int LANES = 4,
    parameter int DW    = 64
) (
    input  logic                  i_clk,
    input  logic [LANES-1:0]      i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DW-1:0]         i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [LANES*DW-1:0]   o_rdata
);

    logic [LANES*DW-1:0] r_mem [WORDS];
    logic [LANES*DW-1:0] r_q;

    always_ff @(posedge i_clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (i_we[l]) begin
                r_mem[i_waddr][l*DW +: DW] <= i_wdata;
            end
        end
        r_q <= r_mem[i_raddr];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/fft_in_loader.sv
// Ping-pong frame loader: serial samples in, LANES-wide words out to the FFT core.
// The read address runs one word ahead so that the registered D outputs meet the stream timing.
module fft_in_loader #(
    parameter int N_FFT = fft_pkg::N_FFT,
    parameter int LANES = fft_pkg::LANES,
    parameter int DW    = fft_pkg::DW
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [DW-1:0] S_DATA,
    output logic          START,
    input  logic          DONE,
    output logic [DW-1:0] D0,
    output logic [DW-1:0] D1,
    output logic [DW-1:0] D2,
    output logic [DW-1:0] D3,
    output logic          BUSY
);

    import fft_pkg::*;

    localparam int L_WORDS = N_FFT / LANES;
    localparam int L_AW    = $clog2(L_WORDS);
    localparam int L_LW    = $clog2(LANES);
    localparam int L_CW    = $clog2(N_FFT);

    localparam logic [L_CW-1:0] L_LAST_S = L_CW'(N_FFT - 1);
    localparam logic [L_AW-1:0] L_LAST_W = L_AW'(L_WORDS - 1);
    localparam logic [L_AW-1:0] L_PRE_W  = L_AW'(L_WORDS - 2);

    rd_state_t           r_state;
    rd_state_t           w_state_nxt;
    logic                r_wbank;
    logic                r_rbank;
    logic [1:0]          r_full;
    logic [1:0]          w_full_nxt;
    logic [L_CW-1:0]     r_wcnt;
    logic [L_AW-1:0]     r_raddr;
    logic [L_AW-1:0]     r_rcnt;
    logic [DW-1:0]       r_d [4];

    logic                w_acc;
    logic                w_fill;
    logic                w_rel;
    logic                w_rinc;
    logic                w_dv;
    logic [LANES-1:0]    w_lane_oh;
    logic [LANES-1:0]    w_we0;
    logic [LANES-1:0]    w_we1;
    logic [L_AW-1:0]     w_waddr;
    logic [LANES*DW-1:0] w_q0;
    logic [LANES*DW-1:0] w_q1;
    logic [LANES*DW-1:0] w_q;

    assign S_READY   = ~r_full[r_wbank];
    assign w_acc     = S_VALID & S_READY;
    assign w_fill    = w_acc && (r_wcnt == L_LAST_S);
    assign w_rel     = (r_state == ST_WLO) && !DONE;
    assign w_waddr   = r_wcnt[L_CW-1:L_LW];
    assign w_lane_oh = LANES'(1) << r_wcnt[L_LW-1:0];
    assign w_we0     = (w_acc && !r_wbank) ? w_lane_oh : '0;
    assign w_we1     = (w_acc &&  r_wbank) ? w_lane_oh : '0;
    assign w_q       = r_rbank ? w_q1 : w_q0;

    fft_bank_ram #(
        .WORDS (L_WORDS),
        .AW    (L_AW),
        .LANES (LANES),
        .DW    (DW)
    ) u_bank0 (
        .i_clk   (CLK),
        .i_we    (w_we0),
        .i_waddr (w_waddr),
        .i_wdata (S_DATA),
        .i_raddr (r_raddr),
        .o_rdata (w_q0)
    );

    fft_bank_ram #(
        .WORDS (L_WORDS),
        .AW    (L_AW),
        .LANES (LANES),
        .DW    (DW)
    ) u_bank1 (
        .i_clk   (CLK),
        .i_we    (w_we1),
        .i_waddr (w_waddr),
        .i_wdata (S_DATA),
        .i_raddr (r_raddr),
        .o_rdata (w_q1)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (r_full[r_rbank]) w_state_nxt = ST_STRT;
            ST_STRT: w_state_nxt = ST_STRM;
            ST_STRM: if (r_rcnt == L_LAST_W) w_state_nxt = ST_WHI;
            ST_WHI:  if (DONE) w_state_nxt = ST_WLO;
            ST_WLO:  if (!DONE) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Fill and release always target different banks, so both may land together.
    always_comb begin
        w_full_nxt = r_full;
        if (w_fill) w_full_nxt[r_wbank] = 1'b1;
        if (w_rel)  w_full_nxt[r_rbank] = 1'b0;
    end

    // Read word k is fetched two cycles before it must sit on D.
    assign w_rinc = ((r_state == ST_IDLE) && r_full[r_rbank])
                 || (r_state == ST_STRT)
                 || ((r_state == ST_STRM) && (r_rcnt < L_PRE_W));

    assign w_dv = (r_state == ST_STRT)
               || ((r_state == ST_STRM) && (r_rcnt != L_LAST_W));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
            r_wbank <= 1'b0;
            r_rbank <= 1'b0;
            r_full  <= 2'b00;
            r_wcnt  <= '0;
            r_raddr <= '0;
            r_rcnt  <= '0;
            for (int k = 0; k < 4; k++) begin
                r_d[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_full  <= w_full_nxt;
            if (w_fill) r_wbank <= ~r_wbank;
            if (w_rel)  r_rbank <= ~r_rbank;
            if (w_acc)  r_wcnt  <= r_wcnt + L_CW'(1);
            if (w_rinc) r_raddr <= r_raddr + L_AW'(1);
            if (r_state == ST_STRM) r_rcnt <= r_rcnt + L_AW'(1);
            for (int k = 0; k < 4; k++) begin
                r_d[k] <= w_dv ? w_q[k*DW +: DW] : '0;
            end
        end
    end

    assign START = (r_state == ST_STRT);
    assign BUSY  = (r_state != ST_IDLE);
    assign D0    = r_d[0];
    assign D1    = r_d[1];
    assign D2    = r_d[2];
    assign D3    = r_d[3];

endmodule

// File: tb/tb_fft_in_loader.sv
// Scoreboard bench: the producer queues expected output words as samples are accepted,
// a negedge monitor pops one per cycle after START and expects zeros elsewhere.
module tb_fft_in_loader;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        S_VALID;
    logic        S_READY;
    logic [63:0] S_DATA;
    logic        START;
    logic        DONE;
    logic [63:0] D0, D1, D2, D3;
    logic        BUSY;

    always #5 CLK = ~CLK;

    fft_in_loader dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .S_VALID (S_VALID),
        .S_READY (S_READY),
        .S_DATA  (S_DATA),
        .START   (START),
        .DONE    (DONE),
        .D0      (D0),
        .D1      (D1),
        .D2      (D2),
        .D3      (D3),
        .BUSY    (BUSY)
    );

    int n_chk = 0;
    int n_err = 0;
    int win = 0;
    int mon_word = 0;
    int frames_seen = 0;
    int acc_cnt = 0;
    logic [255:0] q [$];

    task automatic chk(input string nm, input logic [255:0] got,
                       input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (!RSTn) begin
            win = 0;
        end else begin
            if (win > 0) begin
                if (q.size() == 0) begin
                    chk("q_underflow", {D3, D2, D1, D0}, 256'hx);
                end else begin
                    chk("d_word", {D3, D2, D1, D0}, q.pop_front());
                end
                win--;
                mon_word++;
                if (win == 0) frames_seen++;
            end else begin
                chk("d_idle", {D3, D2, D1, D0}, 256'h0);
            end
            if (START) begin
                chk("start_early", 256'(q.size() >= 1024), 256'd1);
                chk("start_overlap", 256'(win), 256'd0);
                win = 1024;
                mon_word = 0;
            end
        end
    end

    task automatic send_frame(input logic [63:0] base, input bit rnd,
                              input int first, input int last);
        int n;
        n = first;
        while (n < last) begin
            @(negedge CLK);
            S_VALID = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            S_DATA  = base + 64'(n);
            if (S_VALID && S_READY) begin
                if (n % 4 == 3) begin
                    q.push_back({base + 64'(n), base + 64'(n - 1),
                                 base + 64'(n - 2), base + 64'(n - 3)});
                end
                n++;
                acc_cnt++;
            end
        end
        @(negedge CLK);
        S_VALID = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_seen < target && t < 20000) begin
            @(negedge CLK);
            t++;
        end
        chk("frame_done", 256'(frames_seen >= target), 256'd1);
    endtask

    task automatic finish_frame(input int target);
        wait_frames(target);
        @(negedge CLK);
        chk("busy_whi", 256'(BUSY), 256'd1);
        DONE = 1'b1;
        repeat (2) @(negedge CLK);
        DONE = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        repeat (95000) @(posedge CLK);
        n_chk++;
        n_err++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        int t;
        RSTn    = 1'b0;
        DONE    = 1'b0;
        S_VALID = 1'b0;
        S_DATA  = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", 256'(S_READY), 256'd1);
        chk("rst_start", 256'(START), 256'd0);
        chk("rst_busy", 256'(BUSY), 256'd0);
        chk("rst_d", {D3, D2, D1, D0}, 256'h0);
        RSTn = 1'b1;
        @(negedge CLK);
        chk("rel_ready", 256'(S_READY), 256'd1);

        // Single frame, with a DONE pulse in the middle of streaming
        fork
            send_frame(64'h0, 1'b0, 0, 4096);
            begin
                t = 0;
                while (!(win > 0 && mon_word >= 500) && t < 10000) begin
                    @(negedge CLK);
                    t++;
                end
                DONE = 1'b1;
                @(negedge CLK);
                chk("busy_strm", 256'(BUSY), 256'd1);
                DONE = 1'b0;
            end
        join
        finish_frame(1);

        // Three frames back to back, DONE held low until both banks are full
        acc_cnt = 0;
        fork
            begin
                send_frame(64'h10000, 1'b0, 0, 4096);
                send_frame(64'h20000, 1'b0, 0, 4096);
                send_frame(64'h30000, 1'b0, 0, 4096);
            end
            begin
                t = 0;
                while (acc_cnt < 8192 && t < 30000) begin
                    @(negedge CLK);
                    t++;
                end
                @(negedge CLK);
                chk("ready_low", 256'(S_READY), 256'd0);
                repeat (500) @(negedge CLK);
                chk("stall_ready", 256'(S_READY), 256'd0);
                chk("stall_cnt", 256'(acc_cnt), 256'd8192);
                finish_frame(2);
                finish_frame(3);
                finish_frame(4);
            end
        join

        // Random 50% valid, same data as the first frame
        send_frame(64'h0, 1'b1, 0, 4096);
        finish_frame(5);

        // Fill of one bank coincides with release of the other
        send_frame(64'h2000, 1'b0, 0, 4096);
        wait_frames(6);
        send_frame(64'h3000, 1'b0, 0, 4095);
        @(negedge CLK);
        DONE = 1'b1;
        @(negedge CLK);
        chk("coinc_ready", 256'(S_READY), 256'd1);
        DONE    = 1'b0;
        S_VALID = 1'b1;
        S_DATA  = 64'h3000 + 64'd4095;
        q.push_back({64'h3000 + 64'd4095, 64'h3000 + 64'd4094,
                     64'h3000 + 64'd4093, 64'h3000 + 64'd4092});
        @(negedge CLK);
        S_VALID = 1'b0;
        chk("coinc_idle", 256'(START), 256'd0);
        @(negedge CLK);
        chk("coinc_start", 256'(START), 256'd1);
        finish_frame(7);

        // Reset in the middle of a frame
        send_frame(64'h0, 1'b0, 0, 2000);
        @(negedge CLK);
        RSTn = 1'b0;
        q.delete();
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        chk("mrst_ready", 256'(S_READY), 256'd1);
        chk("mrst_busy", 256'(BUSY), 256'd0);
        send_frame(64'h1000, 1'b0, 0, 4096);
        finish_frame(8);
        repeat (5) @(negedge CLK);
        chk("q_empty", 256'(q.size()), 256'd0);
        chk("end_busy", 256'(BUSY), 256'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
